// File: rtl/ei_axi4_rd_arbiter.sv
// ei_axi4_rd_arbiter: N-master to 1-slave AXI4 read-path arbiter.
// AR requests are granted round-robin; the grant index is prepended to ARID
// so R beats can be steered back by the upper RID bits. Each master has a
// bounded number of outstanding read bursts.
module ei_axi4_rd_arbiter #(
  parameter int NUM_MST  = 4,
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_OUTS = 4,
  localparam int IDX_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_MST*ID_W-1:0]   m_arid,
  input  logic [NUM_MST*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MST*8-1:0]      m_arlen,
  input  logic [NUM_MST*3-1:0]      m_arsize,
  input  logic [NUM_MST*2-1:0]      m_arburst,
  input  logic [NUM_MST-1:0]        m_arvalid,
  output logic [NUM_MST-1:0]        m_arready,
  output logic [ID_W-1:0]           m_rid,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [1:0]                m_rresp,
  output logic                      m_rlast,
  output logic [NUM_MST-1:0]        m_rvalid,
  input  logic [NUM_MST-1:0]        m_rready,
  output logic [ID_W+IDX_W-1:0]     s_arid,
  output logic [ADDR_W-1:0]         s_araddr,
  output logic [7:0]                s_arlen,
  output logic [2:0]                s_arsize,
  output logic [1:0]                s_arburst,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  input  logic [ID_W+IDX_W-1:0]     s_rid,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic [1:0]                s_rresp,
  input  logic                      s_rlast,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  output logic                      err_bad_rid
);

  localparam int CNT_W = $clog2(MAX_OUTS + 1);
  localparam logic [CNT_W-1:0] OUTS_LIMIT = CNT_W'(MAX_OUTS);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0] outs_q [NUM_MST];
  logic [CNT_W-1:0] outs_d [NUM_MST];

  logic [NUM_MST-1:0] eligible;
  logic               pickFound;
  logic [IDX_W-1:0]   pickIdx;
  logic               arHandshake;
  logic [IDX_W-1:0]   dest;
  logic               destValid;
  logic               rLastHandshake;

  // A master may compete only while it requests and has room for another burst.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      eligible[i] = m_arvalid[i] && (outs_q[i] < OUTS_LIMIT);
    end
  end

  // Round-robin pick: first eligible master scanning upward from the pointer.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (!pickFound && eligible[(int'(rrPtr_q) + k) % NUM_MST]) begin
        pickFound = 1'b1;
        pickIdx   = IDX_W'((int'(rrPtr_q) + k) % NUM_MST);
      end
    end
  end

  // AR payload always follows the held grant; only the valid is qualified.
  assign s_arid    = {gnt_q, m_arid[int'(gnt_q)*ID_W +: ID_W]};
  assign s_araddr  = m_araddr[int'(gnt_q)*ADDR_W +: ADDR_W];
  assign s_arlen   = m_arlen[int'(gnt_q)*8 +: 8];
  assign s_arsize  = m_arsize[int'(gnt_q)*3 +: 3];
  assign s_arburst = m_arburst[int'(gnt_q)*2 +: 2];

  // Arbitration FSM: IDLE latches a winner, GRANT holds it until the AR handshake.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rrPtr_d     = rrPtr_q;
    s_arvalid   = 1'b0;
    m_arready   = '0;
    arHandshake = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pickFound) begin
          gnt_d   = pickIdx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        s_arvalid        = m_arvalid[gnt_q] && !areset;
        m_arready[gnt_q] = s_arready && !areset;
        if (m_arvalid[gnt_q] && s_arready) begin
          arHandshake = 1'b1;
          rrPtr_d     = (int'(gnt_q) == NUM_MST - 1) ? '0 : gnt_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // R steering by the RID index bits; unknown indices are sunk and flagged.
  always_comb begin
    dest      = s_rid[ID_W +: IDX_W];
    destValid = 1'b0;
    m_rvalid  = '0;
    s_rready  = 1'b1;
    for (int j = 0; j < NUM_MST; j++) begin
      if (dest == IDX_W'(j)) begin
        destValid   = 1'b1;
        m_rvalid[j] = s_rvalid;
        s_rready    = m_rready[j];
      end
    end
  end

  assign rLastHandshake = s_rvalid && s_rready && s_rlast && destValid;
  assign err_bad_rid    = s_rvalid && !destValid && !areset;
  assign m_rid          = s_rid[ID_W-1:0];
  assign m_rdata        = s_rdata;
  assign m_rresp        = s_rresp;
  assign m_rlast        = s_rlast;

  // Outstanding counters: AR accept adds, RLAST removes, both together cancel, floor at zero.
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      outs_d[i] = outs_q[i];
      if (arHandshake && (gnt_q == IDX_W'(i)) &&
          !(rLastHandshake && (dest == IDX_W'(i)))) begin
        outs_d[i] = outs_q[i] + 1'b1;
      end else if (rLastHandshake && (dest == IDX_W'(i)) &&
                   !(arHandshake && (gnt_q == IDX_W'(i))) &&
                   (outs_q[i] != '0)) begin
        outs_d[i] = outs_q[i] - 1'b1;
      end
    end
  end

  // State registers with synchronous reset discarding all tracking.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      rrPtr_q <= '0;
      for (int i = 0; i < NUM_MST; i++) begin
        outs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rrPtr_q <= rrPtr_d;
      for (int i = 0; i < NUM_MST; i++) begin
        outs_q[i] <= outs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ei_axi4_rd_arbiter.sv
// tb_ei_axi4_rd_arbiter: randomized bench for the AXI4 read arbiter with a
// transaction-level reference model (grant owner, round-robin pointer,
// per-master outstanding counts, in-order slave response queue).
module tb_ei_axi4_rd_arbiter;

  localparam int NUM_MST    = 3;
  localparam int ID_W       = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_OUTS   = 3;
  localparam int IDX_W      = 2;
  localparam int SID_W      = ID_W + IDX_W;
  localparam int NUM_CYCLES = 900;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [NUM_MST*ID_W-1:0]   m_arid = '0;
  logic [NUM_MST*ADDR_W-1:0] m_araddr = '0;
  logic [NUM_MST*8-1:0]      m_arlen = '0;
  logic [NUM_MST*3-1:0]      m_arsize = '0;
  logic [NUM_MST*2-1:0]      m_arburst = '0;
  logic [NUM_MST-1:0]        m_arvalid = '0;
  logic [NUM_MST-1:0]        m_arready;
  logic [ID_W-1:0]           m_rid;
  logic [DATA_W-1:0]         m_rdata;
  logic [1:0]                m_rresp;
  logic                      m_rlast;
  logic [NUM_MST-1:0]        m_rvalid;
  logic [NUM_MST-1:0]        m_rready = '0;
  logic [SID_W-1:0]          s_arid;
  logic [ADDR_W-1:0]         s_araddr;
  logic [7:0]                s_arlen;
  logic [2:0]                s_arsize;
  logic [1:0]                s_arburst;
  logic                      s_arvalid;
  logic                      s_arready = 1'b0;
  logic [SID_W-1:0]          s_rid = '0;
  logic [DATA_W-1:0]         s_rdata = '0;
  logic [1:0]                s_rresp = '0;
  logic                      s_rlast = 1'b0;
  logic                      s_rvalid = 1'b0;
  logic                      s_rready;
  logic                      err_bad_rid;

  always #5 aclk = ~aclk;

  ei_axi4_rd_arbiter #(
    .NUM_MST (NUM_MST),
    .ID_W    (ID_W),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_OUTS(MAX_OUTS)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .m_arid      (m_arid),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_arsize    (m_arsize),
    .m_arburst   (m_arburst),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rid       (m_rid),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rlast     (m_rlast),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .s_arid      (s_arid),
    .s_araddr    (s_araddr),
    .s_arlen     (s_arlen),
    .s_arsize    (s_arsize),
    .s_arburst   (s_arburst),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .s_rid       (s_rid),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_rlast     (s_rlast),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .err_bad_rid (err_bad_rid)
  );

  int compareCount = 0;
  int failCount    = 0;

  // Reference model: who holds the grant (-1 = nobody), next priority, outstanding bursts.
  int mdlOwner = -1;
  int mdlRr    = 0;
  int mdlOuts [NUM_MST];
  int nxtOwner = -1;
  int nxtRr    = 0;
  int nxtOuts [NUM_MST];

  // Slave side: accepted bursts answered in order.
  logic [SID_W-1:0] qId [$];
  int               qLen [$];
  int               beatIdx  = 0;
  int               beatKind = 0;

  logic [NUM_MST-1:0] arHsVec = '0;
  logic               rHs     = 1'b0;
  logic               dropAll = 1'b0;
  logic               didReset = 1'b0;
  int                 cyc = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
               tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int phase);
    int  r;
    int  ix;
    logic raise;
    areset = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      m_rready[i] = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < NUM_MST; i++) begin
      if (m_arvalid[i] && arHsVec[i]) m_arvalid[i] = 1'b0;
      if (dropAll) begin
        m_arvalid[i] = 1'b0;
        raise = 1'b0;
      end else if (phase == 0) begin
        raise = (i == 0) && (cyc == 2);
      end else if (phase == 1) begin
        raise = 1'b1;
      end else begin
        raise = ($urandom_range(0, 99) < 40);
      end
      if (!m_arvalid[i] && raise) begin
        m_arvalid[i] = 1'b1;
        if (phase == 0) begin
          m_arid[i*ID_W +: ID_W]     = 4'h5;
          m_araddr[i*ADDR_W +: ADDR_W] = 32'h100;
          m_arlen[i*8 +: 8]          = 8'd3;
          m_arsize[i*3 +: 3]         = 3'd2;
          m_arburst[i*2 +: 2]        = 2'd1;
        end else begin
          m_arid[i*ID_W +: ID_W]     = ID_W'($urandom);
          m_araddr[i*ADDR_W +: ADDR_W] = $urandom;
          m_arlen[i*8 +: 8]          = 8'($urandom_range(0, 3));
          m_arsize[i*3 +: 3]         = 3'($urandom_range(0, 2));
          m_arburst[i*2 +: 2]        = 2'($urandom_range(0, 2));
        end
      end
    end
    dropAll = 1'b0;
    if (phase == 1)      s_arready = 1'b1;
    else if (phase == 2) s_arready = ($urandom_range(0, 9) == 0);
    else                 s_arready = $urandom_range(0, 1) != 0;

    if (s_rvalid && rHs) begin
      if (beatKind == 1) begin
        if (s_rlast) begin
          void'(qId.pop_front());
          void'(qLen.pop_front());
          beatIdx = 0;
        end else begin
          beatIdx++;
        end
      end
      s_rvalid = 1'b0;
      beatKind = 0;
    end
    if (!s_rvalid) begin
      r = $urandom_range(0, 99);
      if (phase >= 1 && r < 6) begin
        ix = (phase == 1) ? 3 : $urandom_range(0, 3);
        s_rid    = {IDX_W'(ix), ID_W'($urandom)};
        s_rlast  = $urandom_range(0, 1) != 0;
        s_rdata  = $urandom;
        s_rresp  = 2'($urandom);
        s_rvalid = 1'b1;
        beatKind = 2;
      end else if (phase != 1 && qId.size() > 0 && r < 60) begin
        s_rid    = qId[0];
        s_rlast  = (beatIdx == qLen[0]);
        s_rdata  = $urandom;
        s_rresp  = 2'($urandom);
        s_rvalid = 1'b1;
        beatKind = 1;
      end
    end
  endtask

  task automatic checkAndPredict();
    logic               expSArv;
    logic [NUM_MST-1:0] expArr;
    logic [NUM_MST-1:0] expRv;
    logic               expSRr;
    logic               expErr;
    logic               arHs;
    int                 d;
    int                 o;
    int                 idx;

    o = mdlOwner;
    expSArv = (o >= 0) && m_arvalid[o];
    expArr  = '0;
    if (o >= 0) expArr[o] = s_arready;
    checkOutput("s_arvalid", s_arvalid, expSArv);
    checkOutput("m_arready", m_arready, expArr);
    if (expSArv) begin
      checkOutput("s_arid", s_arid, {IDX_W'(o), m_arid[o*ID_W +: ID_W]});
      checkOutput("s_araddr", s_araddr, m_araddr[o*ADDR_W +: ADDR_W]);
      checkOutput("s_arlen", s_arlen, m_arlen[o*8 +: 8]);
      checkOutput("s_arsize", s_arsize, m_arsize[o*3 +: 3]);
      checkOutput("s_arburst", s_arburst, m_arburst[o*2 +: 2]);
    end

    d = int'(s_rid[SID_W-1:ID_W]);
    expRv = '0;
    if (d < NUM_MST) begin
      if (s_rvalid) expRv[d] = 1'b1;
      expSRr = m_rready[d];
      expErr = 1'b0;
    end else begin
      expSRr = 1'b1;
      expErr = s_rvalid;
    end
    checkOutput("m_rvalid", m_rvalid, expRv);
    checkOutput("s_rready", s_rready, expSRr);
    checkOutput("err_bad_rid", err_bad_rid, expErr);
    if (s_rvalid) begin
      checkOutput("m_rid", m_rid, s_rid[ID_W-1:0]);
      checkOutput("m_rdata", m_rdata, s_rdata);
      checkOutput("m_rresp", m_rresp, s_rresp);
      checkOutput("m_rlast", m_rlast, s_rlast);
    end

    arHs    = expSArv && s_arready;
    arHsVec = '0;
    if (arHs) arHsVec[o] = 1'b1;
    rHs = s_rvalid && expSRr;

    for (int i = 0; i < NUM_MST; i++) nxtOuts[i] = mdlOuts[i];
    if (arHs) nxtOuts[o]++;
    if (rHs && s_rlast && d < NUM_MST) begin
      nxtOuts[d]--;
      if (nxtOuts[d] < 0) nxtOuts[d] = 0;
    end

    nxtRr    = mdlRr;
    nxtOwner = mdlOwner;
    if (o < 0) begin
      for (int k = 0; k < NUM_MST; k++) begin
        idx = (mdlRr + k) % NUM_MST;
        if (nxtOwner < 0 && m_arvalid[idx] && mdlOuts[idx] < MAX_OUTS) nxtOwner = idx;
      end
    end else if (arHs) begin
      qId.push_back({IDX_W'(o), m_arid[o*ID_W +: ID_W]});
      qLen.push_back(int'(m_arlen[o*8 +: 8]));
      nxtRr    = (o + 1) % NUM_MST;
      nxtOwner = -1;
    end
  endtask

  initial begin
    int phase;
    int outsTotal;
    for (int i = 0; i < NUM_MST; i++) begin
      mdlOuts[i] = 0;
      nxtOuts[i] = 0;
    end
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("reset_s_arvalid", s_arvalid, 1'b0);
    checkOutput("reset_m_arready", m_arready, '0);
    checkOutput("reset_err_bad_rid", err_bad_rid, 1'b0);
    checkOutput("reset_m_rvalid", m_rvalid, '0);

    for (cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      @(posedge aclk);
      #1;
      mdlOwner = nxtOwner;
      mdlRr    = nxtRr;
      outsTotal = 0;
      for (int i = 0; i < NUM_MST; i++) begin
        mdlOuts[i] = nxtOuts[i];
        outsTotal += mdlOuts[i];
      end
      phase = (cyc < 30) ? 0 : (cyc < 120) ? 1 : (cyc < 220) ? 2 : 3;

      if (!didReset && cyc >= 500 && ((mdlOwner >= 0 && outsTotal >= 2) || cyc >= 700)) begin
        didReset = 1'b1;
        areset   = 1'b1;
        s_rvalid = 1'b0;
        beatKind = 0;
        #1;
        checkOutput("midrst_s_arvalid", s_arvalid, 1'b0);
        checkOutput("midrst_m_arready", m_arready, '0);
        checkOutput("midrst_err_bad_rid", err_bad_rid, 1'b0);
        nxtOwner = -1;
        nxtRr    = 0;
        for (int i = 0; i < NUM_MST; i++) nxtOuts[i] = 0;
        qId.delete();
        qLen.delete();
        beatIdx = 0;
        arHsVec = '0;
        rHs     = 1'b0;
        dropAll = 1'b1;
      end else begin
        applyStimulus(phase);
        #1;
        checkAndPredict();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/ei_axi4_rd_arbiter.md
Name: ei_axi4_rd_arbiter

Overview:
Parametrised N-master to 1-slave AXI4 read-path arbiter. It replaces the fixed single-master interconnect for multi-master benches and RTL. AR requests from NUM_MST masters are arbitrated round-robin, and the master index is prepended to ARID. R beats are routed back by the upper RID bits. Each master has an outstanding-read limit.

Parameters:
NUM_MST, 4, number of master ports (2..16)
ID_W, 4, master-side ID width
ADDR_W, 32, address width
DATA_W, 32, read data width
MAX_OUTS, 4, max outstanding AR bursts per master (1..15)

Ports:
aclk  in  1  clock, all logic on posedge
areset  in  1  synchronous active-high reset
m_arid  in  NUM_MST*ID_W  per-master ARID, flattened, master i at slice i
m_araddr  in  NUM_MST*ADDR_W  per-master ARADDR
m_arlen  in  NUM_MST*8  per-master ARLEN
m_arsize  in  NUM_MST*3  per-master ARSIZE
m_arburst  in  NUM_MST*2  per-master ARBURST
m_arvalid  in  NUM_MST  per-master ARVALID
m_arready  out  NUM_MST  per-master ARREADY
m_rid  out  ID_W  RID with index stripped, broadcast to all masters
m_rdata  out  DATA_W  RDATA, broadcast
m_rresp  out  2  RRESP, broadcast
m_rlast  out  1  RLAST, broadcast
m_rvalid  out  NUM_MST  per-master RVALID
m_rready  in  NUM_MST  per-master RREADY
s_arid  out  ID_W+IDX_W  {grant index, ARID}, with IDX_W = max(1,$clog2(NUM_MST))
s_araddr/s_arlen/s_arsize/s_arburst  out  ADDR_W/8/3/2  muxed AR fields
s_arvalid  out  1  ARVALID to slave
s_arready  in  1  ARREADY from slave
s_rid  in  ID_W+IDX_W  RID from slave
s_rdata/s_rresp/s_rlast/s_rvalid  in  DATA_W/2/1/1  R channel from slave
s_rready  out  1  RREADY to slave
err_bad_rid  out  1  one-cycle pulse when an R beat has index >= NUM_MST

Behaviour:
- Reset: state=IDLE, rr_ptr=0, gnt=0, all outstanding counters=0. m_arready=0, s_arvalid=0, err_bad_rid=0. Reset asserted mid-burst discards all tracking; s_arvalid drops in the same cycle.
- Eligible master i: m_arvalid[i] && outs[i] < MAX_OUTS.
- FSM IDLE: if any master is eligible, select the first eligible index scanning rr_ptr, rr_ptr+1, ... mod NUM_MST. Register it into gnt, then go to GRANT. With none eligible, stay in IDLE.
- FSM GRANT:
  - s_ar* = master[gnt] fields; s_arvalid = m_arvalid[gnt]; s_arid = {gnt, m_arid[gnt]}.
  - m_arready[gnt] = s_arready; all other m_arready = 0.
  - On s_arvalid && s_arready: outs[gnt]++, rr_ptr = (gnt+1) mod NUM_MST, go to IDLE.
  - The grant is held until handshake; there is no preemption.
- Latency: first s_arvalid appears 1 cycle after m_arvalid is sampled in IDLE. The minimum AR issue interval is 2 cycles (one IDLE bubble).
- R routing (combinational), with dest = s_rid[ID_W+IDX_W-1:ID_W]:
  - If dest < NUM_MST: m_rvalid[dest] = s_rvalid, s_rready = m_rready[dest], other m_rvalid = 0.
  - On s_rvalid && s_rready && s_rlast: outs[dest]--.
- Bad RID (dest >= NUM_MST): s_rready=1 (beat sunk), all m_rvalid=0, err_bad_rid=1 for each such beat. No counter changes.
- Simultaneous AR handshake and RLAST handshake for the same master: net counter unchanged. The counter never wraps.
- RLAST for a master whose counter is 0 is a protocol error. The counter saturates at 0.
- Counter width is $clog2(MAX_OUTS+1). A master with outs==MAX_OUTS is skipped by the arbiter; others are still served.

Test Plan:
- Single master 0 issues AR addr 0x100, len 3 → s_arid={0,id}; 4 R beats route only to m_rvalid[0]; outs[0] returns 0.
- Masters 0..3 all hold arvalid from reset → grant order 0,1,2,3,0; each s_arvalid starts 1 cycle after IDLE.
- s_arready held low 10 cycles during GRANT to master 2 → s_arvalid and fields stay stable, no grant change; handshake then advances rr_ptr to 3.
- Master 1 issues 4 ARs with no R return (MAX_OUTS=4) → 5th AR is never granted while master 3 is still granted. The RLAST for master 1 re-enables it.
- NUM_MST=3, slave returns RID index 3 → s_rready=1, all m_rvalid=0, err_bad_rid pulses once per beat.
- areset asserted in GRANT with 2 outstanding reads → next cycle state=IDLE, s_arvalid=0, all counters 0.
